// File: rtl/csr_pkg.sv
// Shared definitions for the CSR bus: widths, arbiter FSM encoding and the
// slave/register field layout of a CSR address.
package csr_pkg;

  localparam int CSR_AW = 14;
  localparam int CSR_DW = 32;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } csr_state_e;

  // csr_a[13:10] picks the slave, csr_a[3:0] picks the register inside it
  localparam int CSR_SEL_MSB = 13;
  localparam int CSR_SEL_LSB = 10;
  localparam int CSR_REG_MSB = 3;
  localparam int CSR_REG_LSB = 0;

  function automatic logic [3:0] csr_slave_sel(input logic [CSR_AW-1:0] a);
    return a[CSR_SEL_MSB:CSR_SEL_LSB];
  endfunction

  function automatic logic [3:0] csr_reg_sel(input logic [CSR_AW-1:0] a);
    return a[CSR_REG_MSB:CSR_REG_LSB];
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// master that did not win last time is chosen.
module rr_grant2 (
  input  logic [1:0] stb,
  input  logic       last_grant,
  output logic       gnt,
  output logic       gnt_vld
);

  // Combinational pick from the request pair and the previous winner
  always_comb begin
    gnt_vld = |stb;
    gnt     = 1'b0;
    case (stb)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_arbiter.sv
// Two-master arbiter for the shared CSR bus. Each transaction runs
// IDLE -> ISSUE -> WAIT -> ACK: the bus is driven in ISSUE (one-cycle write
// strobe), the registered slave read data is captured at the end of WAIT and
// handed back with a one-cycle ack in ACK.
module csr_arbiter
  import csr_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_stb,
  input  logic [CSR_AW-1:0] m0_a,
  input  logic              m0_we,
  input  logic [CSR_DW-1:0] m0_dat_w,
  output logic [CSR_DW-1:0] m0_dat_r,
  output logic              m0_ack,
  input  logic              m1_stb,
  input  logic [CSR_AW-1:0] m1_a,
  input  logic              m1_we,
  input  logic [CSR_DW-1:0] m1_dat_w,
  output logic [CSR_DW-1:0] m1_dat_r,
  output logic              m1_ack,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [CSR_DW-1:0] csr_di,
  input  logic [CSR_DW-1:0] csr_do
);

  csr_state_e        state_q;
  csr_state_e        state_d;
  logic              last_grant_q;
  logic              gnt_idx_q;
  logic              pick_idx;
  logic              pick_vld;

  logic              do_load;
  logic              do_unstrobe;
  logic              do_capture;
  logic              do_ack_end;

  logic [CSR_AW-1:0] pick_a;
  logic              pick_we;
  logic [CSR_DW-1:0] pick_dat_w;

  rr_grant2 u_rr (
    .stb        ({m1_stb, m0_stb}),
    .last_grant (last_grant_q),
    .gnt        (pick_idx),
    .gnt_vld    (pick_vld)
  );

  // Route the picked master's request onto the bus loading path
  always_comb begin
    pick_a     = pick_idx ? m1_a     : m0_a;
    pick_we    = pick_idx ? m1_we    : m0_we;
    pick_dat_w = pick_idx ? m1_dat_w : m0_dat_w;
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-state actions applied to the registers below
  always_comb begin
    do_load     = 1'b0;
    do_unstrobe = 1'b0;
    do_capture  = 1'b0;
    do_ack_end  = 1'b0;
    case (state_q)
      ST_IDLE:  do_load     = pick_vld;
      ST_ISSUE: do_unstrobe = 1'b1;
      ST_WAIT:  do_capture  = 1'b1;
      ST_ACK:   do_ack_end  = 1'b1;
      default:  ;
    endcase
  end

  // Arbitration memory: who won last, who owns the current transaction
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_grant_q <= 1'b1;
      gnt_idx_q    <= 1'b0;
    end else if (do_load) begin
      last_grant_q <= pick_idx;
      gnt_idx_q    <= pick_idx;
    end
  end

  // Shared bus registers: load on grant, drop strobe after ISSUE, idle after WAIT
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_a  <= '0;
      csr_we <= 1'b0;
      csr_di <= '0;
    end else if (do_load) begin
      csr_a  <= pick_a;
      csr_we <= pick_we;
      csr_di <= pick_dat_w;
    end else if (do_unstrobe) begin
      csr_we <= 1'b0;
    end else if (do_capture) begin
      csr_a  <= '0;
      csr_we <= 1'b0;
      csr_di <= '0;
    end
  end

  // Completion: capture slave data into the grantee's dat_r and pulse its ack
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m0_dat_r <= '0;
      m1_dat_r <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
    end else if (do_capture) begin
      if (gnt_idx_q) begin
        m1_dat_r <= csr_do;
        m1_ack   <= 1'b1;
      end else begin
        m0_dat_r <= csr_do;
        m0_ack   <= 1'b1;
      end
    end else if (do_ack_end) begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
    end
  end

endmodule

// File: doc/csr_arbiter.md
# csr_arbiter

Two-master arbiter for the shared CSR bus. It serialises register transactions from two independent requesters onto the single csr_a/csr_we/csr_di/csr_do bus that all CSR peripherals (GPIO, etc.) decode. Typical use: master 0 is the CPU-to-CSR bridge and master 1 is a debug/UART command port, both able to read and write peripheral registers without colliding. Grants are round-robin and each transaction completes with a one-cycle ack carrying read data.

## Interface
Parameters:
- none; master count fixed at 2, bus widths fixed at 14-bit address and 32-bit data.

Ports:
- sys_clk  in  1  system clock; single clock domain. All registers are on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- m0_stb  in  1  master 0 request; held with a/we/dat_w until m0_ack.
- m0_a  in  14  master 0 CSR address.
- m0_we  in  1  master 0 write enable (1 = write, 0 = read).
- m0_dat_w  in  32  master 0 write data.
- m0_dat_r  out  32  master 0 read data; valid only in the m0_ack cycle.
- m0_ack  out  1  master 0 completion pulse, one cycle.
- m1_stb, m1_a, m1_we, m1_dat_w, m1_dat_r, m1_ack: identical to master 0.
- csr_a  out  14  shared CSR address, registered.
- csr_we  out  1  shared CSR write strobe, registered.
- csr_di  out  32  shared CSR write data, registered.
- csr_do  in  32  OR of all slave read data. Slaves register it, so it is valid one cycle after the address is presented.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE
  - csr_a=0, csr_we=0, csr_di=0.
  - If any stb is high, pick the grantee, load csr_a/csr_we/csr_di from it, then go to ISSUE.
- ISSUE
  - Bus carries the grantee's transaction.
  - Slaves sample csr_we/csr_di and register csr_do at the end of this cycle.
  - Go to WAIT.
- WAIT
  - csr_a is held and csr_we is forced 0, so a write strobe lasts exactly one cycle.
  - csr_di is held.
  - csr_do is captured into the grantee's dat_r at the end of this cycle; go to ACK.
- ACK
  - Grantee's ack=1 and dat_r is valid.
  - Bus returns to the idle values; go to IDLE.
- Arbitration (IDLE only)
  - If only one stb is high, that master is granted.
  - If both are high, grant the master other than last_grant.
  - last_grant updates on every grant and resets to 1, so master 0 wins the first tie.
- Write transactions also return data: dat_r is the slave's pre-write readback. For example, GPIO returns the old gpio_outputs value.
- Non-granted master: ack=0; its dat_r keeps its previous value.
- Address decode is not performed. An unmapped address returns 0, because no slave drives csr_do.

## Timing
- Reset values: csr_a=0, csr_we=0, csr_di=0, m0_ack=m1_ack=0, m0_dat_r=m1_dat_r=0, state=IDLE, last_grant=1.
- Latency: stb high in cycle N (arbiter in IDLE) gives ISSUE in N+1, WAIT in N+2, and ack in N+3.
- Throughput: at most one transaction per 4 cycles.
- Master rules:
  - hold stb, a, we and dat_w stable from assertion through the ack cycle;
  - deassert stb, or present a new request, no earlier than the cycle after ack;
  - stb seen during ISSUE/WAIT/ACK is ignored until IDLE.
- A master that changes a/we/dat_w before ack is a protocol violation; behaviour is undefined and need not be checked.
- Simultaneous stb in the same IDLE cycle: exactly one grant per the round-robin rule. The loser is served in the next transaction, starting at N+4.
- Reset mid-transaction (any state):
  - next cycle is IDLE with all outputs at reset values;
  - the in-flight transaction is dropped and no ack is issued;
  - a write already strobed in ISSUE stays committed at the slave unless the slave is also reset.
- Acks are never asserted to both masters in the same cycle.

## Structure
- Shared package csr_pkg:
  - CSR_AW=14, CSR_DW=32;
  - FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, ACK=3);
  - CSR slave field layout: csr_a[13:10] selects the slave, csr_a[3:0] selects the register.
- One natural sub-module, rr_grant2: combinational two-way round-robin pick from {stb1, stb0, last_grant}. It yields a grant index and a valid flag and is reusable for a later N-way version.
- csr_arbiter holds the FSM, the bus output registers, last_grant and the per-master dat_r/ack registers.

## Test plan
- Reset then idle:
  - hold sys_rst 2 cycles with no stb;
  - expect all outputs 0 and csr_we never asserted over 20 cycles.
- Single write/read via GPIO slave at csr_addr 4'h0:
  - m0 writes a=14'h0001, dat_w=32'hDEADBEEF: csr_we is high exactly one cycle (N+1) and m0_ack arrives at N+3;
  - m0 then reads a=14'h0001: m0_dat_r=32'hDEADBEEF with ack.
- Simultaneous requests:
  - m0 and m1 both read 14'h0001 in the same cycle after reset: m0 is acked first, m1 four cycles later;
  - repeat both together: m1 first this time (alternation).
- Write readback: GPIO holds 32'h00000005; m1 writes 32'h0000000A. m1_dat_r=32'h00000005 with ack, and a subsequent read returns 32'h0000000A.
- Unmapped address: m0 reads 14'h3C01. m0_dat_r=0 with ack at N+3.
- Reset mid-transaction: assert sys_rst during WAIT of an m1 read. No m1_ack, outputs are 0 the next cycle, and a fresh m1 request completes normally at N+3.
